// File: rtl/regfile_loader_if.sv
// Stream-in and register-file port bundle for the register-file loader.
// The loader takes the slave side; the source and register file take the master side.
interface regfile_loader_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [AW-1:0]    rf_raddr;
    logic [WIDTH-1:0] rf_rdata;

    modport master (
        output in_data, in_valid, rf_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, rf_raddr
    );

    modport slave (
        input  in_data, in_valid, rf_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, rf_raddr
    );
endinterface

// File: rtl/regfile_loader.sv
// Loads the register file from a valid/ready word stream, then optionally
// reads it back and compares XOR checksums of written and readback data.
module regfile_loader #(
    parameter int WIDTH     = 32,
    parameter int NREGS     = 32,
    parameter int AW        = 5,
    parameter int SKIP_R0   = 1,
    parameter int VERIFY_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    regfile_loader_if.slave bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count
);
    typedef enum logic [2:0] {
        IDLE, LOAD, VERIFY, CHECK, DONE
    } state_t;

    localparam logic [AW:0] SIDX = (AW+1)'(SKIP_R0 != 0 ? 1 : 0);
    localparam logic [AW:0] LIDX = (AW+1)'(NREGS - 1);
    localparam logic [AW:0] CMAX = (AW+1)'(NREGS);

    state_t           state;
    state_t           state_n;
    logic [AW:0]      idx;
    logic [WIDTH-1:0] wsum;
    logic [WIDTH-1:0] rsum;
    logic             rdy_q;
    logic             go;
    logic             beat;
    logic             at_last;

    assign go      = start & ~abort & ((state == IDLE) | (state == DONE));
    assign beat    = (state == LOAD) & bus.in_valid & rdy_q & ~abort;
    assign at_last = (idx == LIDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (start) state_n = LOAD;
                LOAD: begin
                    if (beat && at_last)
                        state_n = (VERIFY_EN != 0) ? VERIFY : DONE;
                end
                VERIFY: if (at_last) state_n = CHECK;
                CHECK:  state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state == LOAD) | (state == VERIFY) | (state == CHECK);
        done         = (state == DONE);
        bus.in_ready = rdy_q;
        bus.rf_we    = beat;
        bus.rf_waddr = beat ? idx[AW-1:0] : '0;
        bus.rf_wdata = beat ? bus.in_data : '0;
        bus.rf_raddr = (state == VERIFY) ? idx[AW-1:0] : '0;
    end

    // idx serves as the write index in LOAD and the readback index in VERIFY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            wsum  <= '0;
            rsum  <= '0;
            count <= '0;
            err   <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= (state_n == LOAD);
            if (abort) begin
                err <= 1'b0;
            end else if (go) begin
                idx   <= SIDX;
                wsum  <= '0;
                rsum  <= '0;
                count <= '0;
                err   <= 1'b0;
            end else if (beat) begin
                wsum  <= wsum ^ bus.in_data;
                count <= (count == CMAX) ? count : count + 1'b1;
                idx   <= at_last ? SIDX : idx + 1'b1;
            end else if (state == VERIFY) begin
                rsum <= rsum ^ bus.rf_rdata;
                idx  <= idx + 1'b1;
            end else if (state == CHECK) begin
                err <= (rsum != wsum);
            end
        end
    end
endmodule

// File: tb/tb_regfile_loader.sv
// Scoreboard bench for regfile_loader: default config (u0) and
// SKIP_R0=0 / VERIFY_EN=0 config (u1), with a behavioural register file.
module tb_regfile_loader;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    typedef struct packed {
        logic       e;
        logic [5:0] c;
    } res_t;

    logic clk;
    logic rst_n;
    logic sel;
    logic start;
    logic abort;
    logic v;
    logic [31:0] d;
    logic corrupt7;
    int   cyc;
    int   errors;
    int   checks;
    int   done_cyc;

    logic [31:0] rf [32];
    logic [31:0] exp_rf [32];
    bit          known [32];
    wr_t  sb[$];
    res_t rq[$];

    regfile_loader_if #(.WIDTH(32), .AW(5)) b0 ();
    regfile_loader_if #(.WIDTH(32), .AW(5)) b1 ();

    logic       busy0, done0, err0, busy1, done1, err1;
    logic [5:0] count0, count1;

    regfile_loader u0 (
        .clk(clk), .rst_n(rst_n),
        .start(start & ~sel), .abort(abort & ~sel),
        .bus(b0.slave),
        .busy(busy0), .done(done0), .err(err0), .count(count0)
    );

    regfile_loader #(.SKIP_R0(0), .VERIFY_EN(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .start(start & sel), .abort(abort & sel),
        .bus(b1.slave),
        .busy(busy1), .done(done1), .err(err1), .count(count1)
    );

    assign b0.in_data  = d;
    assign b1.in_data  = d;
    assign b0.in_valid = v & ~sel;
    assign b1.in_valid = v & sel;
    // Register file model reads asynchronously; r7 can be forced bad on readback
    assign b0.rf_rdata = (b0.rf_raddr == 5'd7 && corrupt7) ? 32'hDEADBEEF : rf[b0.rf_raddr];
    assign b1.rf_rdata = (b1.rf_raddr == 5'd7 && corrupt7) ? 32'hDEADBEEF : rf[b1.rf_raddr];

    logic        m_we, m_ready, m_busy, m_done, m_err;
    logic [4:0]  m_waddr, m_raddr;
    logic [31:0] m_wdata;
    logic [5:0]  m_count;

    assign m_we    = sel ? b1.rf_we    : b0.rf_we;
    assign m_waddr = sel ? b1.rf_waddr : b0.rf_waddr;
    assign m_wdata = sel ? b1.rf_wdata : b0.rf_wdata;
    assign m_raddr = sel ? b1.rf_raddr : b0.rf_raddr;
    assign m_ready = sel ? b1.in_ready : b0.in_ready;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_done  = sel ? done1  : done0;
    assign m_err   = sel ? err1   : err0;
    assign m_count = sel ? count1 : count0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_we) rf[m_waddr] <= m_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expected writes and results as the DUT presents them
    initial begin : monitor
        wr_t  e;
        res_t r;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (m_we) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got r%0d=%0h expected none", m_waddr, m_wdata);
                    end else begin
                        e = sb.pop_front();
                        chk("waddr", 64'(m_waddr), 64'(e.a));
                        chk("wdata", 64'(m_wdata), 64'(e.d));
                    end
                end
                if (m_done && !prev_done) begin
                    done_cyc = cyc;
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected 0");
                    end else begin
                        r = rq.pop_front();
                        chk("err", 64'(m_err), 64'(r.e));
                        chk("count", 64'(m_count), 64'(r.c));
                    end
                end
                prev_done = m_done;
            end
        end
    end

    task automatic check_regs();
        for (int i = 0; i < 32; i++) begin
            if (known[i]) chk($sformatf("reg%0d", i), 64'(rf[i]), 64'(exp_rf[i]));
        end
    endtask

    task automatic do_load(input int gap, input int abort_at, input bit corrupt,
                           input bit rst_verify, input bit poke, input bit seqdata,
                           input int exp_lat);
        int s, n, k, t, st, lim;
        logic [31:0] w;
        bit go;
        logic e;
        s = sel ? 0 : 1;
        n = sel ? 32 : 31;
        k = 0;
        t = 0;
        @(negedge clk);
        start = 1'b1;
        st = cyc;
        corrupt7 = corrupt;
        @(negedge clk);
        start = 1'b0;
        while (k < n) begin
            chk("in_ready_load", 64'(m_ready), 64'd1);
            if (k == abort_at) begin
                v = 1'b1;
                d = $urandom;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                v = 1'b0;
                #1;
                chk("abort_busy", 64'(m_busy), 64'd0);
                chk("abort_done", 64'(m_done), 64'd0);
                chk("abort_ready", 64'(m_ready), 64'd0);
                chk("abort_count", 64'(m_count), 64'(abort_at));
                return;
            end
            case (gap)
                0:       go = 1'b1;
                1:       go = (t % 2 == 0);
                default: go = ($urandom_range(0, 3) != 0);
            endcase
            w = seqdata ? 32'(k + 1) : $urandom;
            if (corrupt && s + k == 7 && w == 32'hDEADBEEF) w = 32'h0;
            start = poke && (t == 5);
            v = go;
            d = w;
            if (go) begin
                sb.push_back('{a: 5'(s + k), d: w});
                exp_rf[s + k] = w;
                known[s + k] = 1'b1;
                k++;
            end
            t++;
            @(negedge clk);
        end
        v = 1'b0;
        start = 1'b0;
        #1;
        chk("in_ready_drop", 64'(m_ready), 64'd0);
        if (rst_verify) begin
            repeat (5) @(negedge clk);
            chk("busy_in_verify", 64'(m_busy), 64'd1);
            rst_n = 1'b0;
            #1;
            chk("rst_busy", 64'(m_busy), 64'd0);
            chk("rst_done", 64'(m_done), 64'd0);
            chk("rst_err", 64'(m_err), 64'd0);
            chk("rst_count", 64'(m_count), 64'd0);
            chk("rst_ready", 64'(m_ready), 64'd0);
            chk("rst_raddr", 64'(m_raddr), 64'd0);
            chk("rst_we", 64'(m_we), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            corrupt7 = 1'b0;
            return;
        end
        e = corrupt ? (exp_rf[7] != 32'hDEADBEEF) : 1'b0;
        rq.push_back('{e: e, c: 6'(n)});
        lim = 0;
        while (rq.size() != 0 && lim < 200) begin
            @(negedge clk);
            #3;
            lim++;
        end
        if (rq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
            rq.delete();
        end else if (exp_lat > 0) begin
            chk("latency", 64'(done_cyc - st), 64'(exp_lat));
        end
        corrupt7 = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        done_cyc = 0;
        sel = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        v = 1'b0;
        d = '0;
        corrupt7 = 1'b0;
        for (int i = 0; i < 32; i++) known[i] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", 64'(m_busy), 64'd0);
        chk("reset_done", 64'(m_done), 64'd0);
        chk("reset_err", 64'(m_err), 64'd0);
        chk("reset_count", 64'(m_count), 64'd0);
        chk("reset_ready", 64'(m_ready), 64'd0);
        chk("reset_we", 64'(m_we), 64'd0);
        chk("reset_waddr", 64'(m_waddr), 64'd0);
        chk("reset_wdata", 64'(m_wdata), 64'd0);
        chk("reset_raddr", 64'(m_raddr), 64'd0);
        rst_n = 1'b1;

        do_load(0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 64);
        check_regs();
        do_load(1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check_regs();
        do_load(2, -1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_regs();

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("startabort_done", 64'(m_done), 64'd0);
        chk("startabort_busy", 64'(m_busy), 64'd0);
        chk("startabort_err", 64'(m_err), 64'd0);
        chk("startabort_count", 64'(m_count), 64'd31);

        do_load(0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_regs();
        do_load(2, -1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        check_regs();
        do_load(0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        do_load(0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 64);
        check_regs();

        @(negedge clk);
        sel = 1'b1;
        do_load(0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 33);
        check_regs();
        do_load(2, -1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_regs();

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_loader.md
Name: regfile_loader

Overview:
- Loads the 32-entry CPU register file from a word stream; the counterpart of the per-cycle register-file dump.
- Accepts words over a valid/ready input and drives the register-file write port with one word per accepted beat, in ascending index order.
- Optionally reads every loaded register back through a read port and compares an XOR checksum of the readback against an XOR checksum of the words written.
- Sits beside the register file; used to preload register state for bring-up and test programs.

Parameters:
WIDTH, 32, data width of the stream and the register file.
NREGS, 32, number of registers.
AW, 5, register address width; must satisfy 2^AW >= NREGS.
SKIP_R0, 1, 1 = start at index 1 (r0 hardwired zero), 0 = start at index 0.
VERIFY_EN, 1, 1 = readback checksum pass after load, 0 = go straight to DONE.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset; asynchronous, active-low.
start  in  1  one-cycle request to begin a load; ignored unless state is IDLE or DONE.
abort  in  1  synchronous abort; returns to IDLE from any state.
in_data  in  WIDTH  stream word.
in_valid  in  1  in_data is valid.
in_ready  out  1  loader accepts a word this cycle.
rf_we  out  1  register-file write enable.
rf_waddr  out  AW  register-file write address.
rf_wdata  out  WIDTH  register-file write data.
rf_raddr  out  AW  register-file read address; the register file reads asynchronously.
rf_rdata  in  WIDTH  register-file read data for rf_raddr, same cycle.
busy  out  1  high in LOAD, VERIFY and CHECK.
done  out  1  high in DONE.
err  out  1  checksum mismatch flag; meaningful while done=1.
count  out  AW+1  number of words written in the current or last load.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; idx=0; wsum=0; rsum=0; count=0; err=0.
  - in_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_raddr=0, busy=0, done=0.
  - Reset mid-load leaves registers already written unchanged; the load must be restarted.
- Start index S = SKIP_R0 ? 1 : 0. Last index L = NREGS-1. A load consumes L-S+1 words: 31 with defaults.
- States and transitions:
  - IDLE: on start, go to LOAD; idx=S, wsum=0, rsum=0, count=0, err=0.
  - DONE: holds done=1 and err until the next start or abort. A start in DONE behaves as in IDLE.
  - LOAD:
    - in_ready=1 for the whole state; it is a registered function of the state.
    - Handshake beat = in_valid & in_ready.
    - On a beat: rf_we=1, rf_waddr=idx, rf_wdata=in_data (combinational, zero latency, same cycle). wsum ^= in_data; count++; idx++.
    - Without a beat: rf_we=0 and idx holds. Gaps in in_valid are legal at any point.
    - Beat at idx==L: next state is VERIFY with vidx=S if VERIFY_EN, else DONE. in_ready drops the following cycle.
  - VERIFY (one register per cycle):
    - rf_raddr=vidx; rsum ^= rf_rdata; vidx++.
    - At vidx==L, go to CHECK.
    - Verification uses exactly L-S+1 cycles. The last write landed on the clock edge before VERIFY is entered, so there is no hazard.
  - CHECK (one cycle): err=(rsum != wsum); go to DONE.
- Outside LOAD: rf_we=0 and in_ready=0. rf_raddr=0 outside VERIFY.
- abort in any state:
  - Next state is IDLE; done=0, err=0.
  - rf_we is gated low in the abort cycle, so no write occurs even if in_valid=1.
  - count keeps its value.
- Simultaneous start and abort: abort wins.
- start while busy: ignored, with no effect on idx or the checksums.
- Index counters are AW+1 bits wide, so they never wrap during a load. count saturates at NREGS.
- Checksums are full WIDTH bits, bitwise XOR, with no carries.

Test Plan:
- Basic load with defaults: start, then stream words 0x00000001..0x0000001F with in_valid held high.
  - Expect 31 writes to r1..r31 on consecutive cycles.
  - Expect VERIFY for 31 cycles, CHECK, then done=1, err=0, count=31.
  - Total latency from start to done is 1+31+31+1 cycles.
- Bubbled stream: the same data with in_valid toggling 1,0,1,0.
  - Writes occur only on beats, with addresses still r1..r31 in order.
  - Final register contents and err=0 are identical to the basic load.
- Corrupted readback: the bench model forces rf_rdata for r7 to 0xDEADBEEF during VERIFY.
  - Expect done=1, err=1.
- Abort mid-load: abort asserted after 10 beats.
  - Expect IDLE next cycle and no rf_we in the abort cycle.
  - r1..r10 are written and r11..r31 are untouched; done=0, count=10.
  - A following start reloads fully with err=0.
- Reset mid-verify: rst_n pulsed low for one cycle during VERIFY.
  - All outputs return to their reset values immediately, before the next clock edge.
  - start is then accepted normally.
- SKIP_R0=0, VERIFY_EN=0: stream 32 words.
  - Writes go to r0..r31; done is asserted the cycle after the 32nd beat; err=0, count=32.
